mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: Parameter DATA_WIDTH, default 32, width of all address and data buses.
REQ-002: Parameter TIMEOUT, default 15, maximum cycles to wait for mem_rvalid before an error response; value in range 1..255.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  asynchronous, active-low reset.
REQ-005: if_req_i  input  1  fetch port requests a read.
REQ-006: if_addr_i  input  DATA_WIDTH  fetch address.
REQ-007: if_rdata_o  output  DATA_WIDTH  fetch read data.
REQ-008: if_valid_o  output  1  one-cycle fetch completion pulse.
REQ-009: d_req_i  input  1  data port requests an access.
REQ-010: d_we_i  input  1  data access is a write.
REQ-011: d_addr_i / d_wdata_i  input  DATA_WIDTH each  data address and write data.
REQ-012: d_be_i  input  4  data byte enables.
REQ-013: d_rdata_o  output  DATA_WIDTH  data read result.
REQ-014: d_valid_o  output  1  one-cycle data completion pulse.
REQ-015: d_err_o  output  1  pulses with d_valid_o on timeout.
REQ-016: if_err_o  output  1  pulses with if_valid_o on timeout.
REQ-017: mem_req_o, mem_we_o  output  1 each  memory request and write strobe.
REQ-018: mem_addr_o, mem_wdata_o  output  DATA_WIDTH each; mem_be_o  output  4.
REQ-019: mem_gnt_i  input  1  memory accepts the current request.
REQ-020: mem_rvalid_i  input  1  memory completion; mem_rdata_i  input  DATA_WIDTH.

Function
REQ-021: The block SHALL share one single-port memory between the fetch and data ports, with at most one transaction outstanding.
REQ-022: The FSM SHALL have states IDLE, REQ (mem_req_o high, waiting for mem_gnt_i) and RESP (waiting for mem_rvalid_i).
REQ-023: IDLE->REQ when any request is present, latching the winner's addr/wdata/be/we into registers that drive mem_* outputs.
REQ-024: REQ->RESP on the cycle mem_gnt_i=1; mem_req_o SHALL deassert on the following cycle.
REQ-025: RESP->IDLE on mem_rvalid_i=1 or on timeout; the owner's valid pulses on that same edge, registered and high for exactly one cycle.
REQ-026: Arbitration when both ports request in IDLE: round-robin, with the grant going to the port not served last; a single requester is always granted.
REQ-027: After reset the last-served pointer SHALL equal fetch, so the data port wins the first tie.
REQ-028: Fetch grants SHALL force mem_we_o=0 and mem_be_o=4'b1111.
REQ-029: Read data SHALL be captured from mem_rdata_i into the owner's rdata register on mem_rvalid_i and held until that port's next completion.
REQ-030: Writes complete on mem_rvalid_i; d_rdata_o is unchanged for writes.
REQ-031: A timeout counter SHALL start at 0 on REQ entry, increment each cycle in REQ or RESP, and on reaching TIMEOUT force completion with err=1 and rdata=0.
REQ-032: Requesters hold req and operands stable until their valid pulse; the block SHALL NOT re-sample latched operands mid-transaction.
REQ-033: A request still asserted on the completion cycle is treated as a new request; re-arbitration happens in IDLE on the next cycle, with a minimum of one IDLE cycle between transactions.
REQ-034: mem_rvalid_i in IDLE or REQ SHALL be ignored.
REQ-035: mem_gnt_i and mem_rvalid_i arriving in the same cycle while in REQ SHALL be treated as grant only.

Reset
REQ-036: While rst=0, the state SHALL be IDLE, and all outputs, the counter and the latched registers SHALL be 0.
REQ-037: Reset asserted mid-transaction SHALL abort it with no valid or err pulse, and the pointer SHALL return to fetch.
REQ-038: The first request SHALL be sampled on the first rising edge after rst rises.

Verification
REQ-039: Fetch only, addr=0x100, gnt after 1 cycle, rvalid 2 cycles later with 0xDEADBEEF -> if_valid_o pulses once, if_rdata_o=0xDEADBEEF, mem_we_o=0.
REQ-040: Both ports request after reset -> data is served first, then fetch; continuous requests alternate D,F,D,F.
REQ-041: Data write, addr=0x2000, wdata=0x12345678, be=4'b0011 -> mem_* outputs carry these values, and d_valid_o pulses with d_rdata_o unchanged.
REQ-042: rvalid never returns, TIMEOUT=15 -> at cycle 15 after REQ entry, d_valid_o=d_err_o=1, d_rdata_o=0, and the FSM returns to IDLE.
REQ-043: rst driven low while in RESP -> outputs 0 immediately, no valid pulse; after release the next tie is granted to data.
REQ-044: gnt and rvalid in the same cycle while in REQ -> the FSM moves to RESP only, and a later rvalid completes the transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data ports, one access in
// flight, round-robin on ties, and a per-access timeout that returns an error.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_valid_o,
    output logic                  if_err_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    input  logic [3:0]            d_be_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_valid_o,
    output logic                  d_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  if_valid_q, if_valid_d;
    logic                  d_valid_q, d_valid_d;
    logic                  if_err_q, if_err_d;
    logic                  d_err_q, d_err_d;
    logic                  pick_d;
    logic                  fin;
    logic                  fin_err;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_err_d   = 1'b0;
        d_err_d    = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        // owner/last encoding: 1 = data port, 0 = fetch port
        pick_d     = d_req_i && (!if_req_i || !last_q);

        unique case (state_q)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    owner_d = pick_d;
                    last_d  = pick_d;
                    if (pick_d) begin
                        addr_d  = d_addr_i;
                        wdata_d = d_wdata_i;
                        be_d    = d_be_i;
                        we_d    = d_we_i;
                    end else begin
                        addr_d  = if_addr_i;
                        wdata_d = '0;
                        be_d    = 4'hF;
                        we_d    = 1'b0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (mem_gnt_i) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                end
            end
            RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid_i) begin
                    fin = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d = IDLE;
            req_d   = 1'b0;
            cnt_d   = '0;
            if (owner_q) begin
                d_valid_d = 1'b1;
                d_err_d   = fin_err;
                if (fin_err) begin
                    d_rdata_d = '0;
                end else if (!we_q) begin
                    d_rdata_d = mem_rdata_i;
                end
            end else begin
                if_valid_d = 1'b1;
                if_err_d   = fin_err;
                if_rdata_d = fin_err ? '0 : mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_err_q   <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_err_q   <= if_err_d;
            d_err_q    <= d_err_d;
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign if_err_o    = if_err_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_valid_o   = d_valid_q;
    assign d_err_o     = d_err_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, with a
// memory responder and a scoreboard of expected completions per port.
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        if_err_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_rdata_o;
    logic        d_valid_o;
    logic        d_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    exp_t        if_q[$];
    exp_t        d_q[$];
    int          served_q[$];
    logic [31:0] ref_d [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] last_d = '0;

    int          cfg_gd = -1;
    int          cfg_rd = -1;
    bit          cfg_drop = 0;
    bit          cfg_noise = 0;
    bit          cfg_force = 0;
    bit          cfg_rvg = 0;
    logic [31:0] cfg_data = '0;

    mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_err_o(if_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
        .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_err_o(d_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5EED_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_d.exists(a) ? ref_d[a] : pat(a);
    endfunction

    function automatic logic [31:0] rmem_rd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : pat(a);
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic e);
        exp_t r;
        r.data = d;
        r.err  = e;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic issue_f(input logic [31:0] a);
        if_req_i  = 1'b1;
        if_addr_i = a;
        if_q.push_back(mk(pat(a), 1'b0));
    endtask

    task automatic issue_d(input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        d_req_i   = 1'b1;
        d_we_i    = we;
        d_addr_i  = a;
        d_wdata_i = wd;
        d_be_i    = be;
        if (we) begin
            ref_d[a] = merge(ref_rd(a), wd, be);
        end else begin
            last_d = ref_rd(a);
        end
        d_q.push_back(mk(last_d, 1'b0));
    endtask

    task automatic wait_valid(input bit dport, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dport ? d_valid_o : if_valid_o) && n < budget);
        checks++;
        if (!(dport ? d_valid_o : if_valid_o)) begin
            errors++;
            $display("FAIL wait_valid: no completion in %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        if_q.delete();
        d_q.delete();
        last_d = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_ports(input int n, input bit rnd);
        int issued, done, cyc, k;
        bit pf, pd;
        issued = 0; done = 0; cyc = 0; k = 0; pf = 0; pd = 0;
        while (done < n && cyc < n * 40 + 40) begin
            @(negedge clk);
            cyc++;
            if (pf && if_valid_o) begin pf = 0; done++; if_req_i = 1'b0; end
            if (pd && d_valid_o) begin pd = 0; done++; d_req_i = 1'b0; end
            if (!pd && issued < n && (!rnd || $urandom_range(0, 1) == 1)) begin
                if (rnd)
                    issue_d($urandom_range(0, 1) == 1,
                            32'h2000 + 32'(4 * $urandom_range(0, 15)),
                            $urandom, 4'($urandom));
                else
                    issue_d(1'b0, 32'h2000 + 32'(4 * k), '0, 4'hF);
                pd = 1; issued++; k++;
            end
            if (!pf && issued < n && (!rnd || $urandom_range(0, 1) == 1)) begin
                if (rnd) issue_f(32'h1000 + 32'(4 * $urandom_range(0, 63)));
                else     issue_f(32'h1000 + 32'(4 * k));
                pf = 1; issued++; k++;
            end
        end
        checks++;
        if (done < n) begin
            errors++;
            $display("FAIL run_ports: %0d of %0d completions", done, n);
        end
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
    endtask

    // Memory model: accepts on gnt, answers after a delay, optional noise.
    task automatic accept(output logic [31:0] rsp);
        bit ok_f, ok_d;
        ok_f = if_req_i && mem_addr_o == if_addr_i && !mem_we_o
               && mem_be_o == 4'hF;
        ok_d = d_req_i && mem_addr_o == d_addr_i && mem_we_o == d_we_i
               && mem_be_o == d_be_i && (!d_we_i || mem_wdata_o == d_wdata_i);
        check("mem_match", 32'(ok_f | ok_d), 32'd1);
        served_q.push_back(ok_d ? 1 : (ok_f ? 0 : 2));
        if (mem_we_o) begin
            rmem[mem_addr_o] = merge(rmem_rd(mem_addr_o), mem_wdata_o, mem_be_o);
            rsp = $urandom;
        end else begin
            rsp = rmem_rd(mem_addr_o);
        end
        if (cfg_force) rsp = cfg_data;
    endtask

    initial begin
        int          rphase, rcnt;
        logic [31:0] rsp;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        rphase = 0; rcnt = 0; rsp = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            if (!rst) begin
                rphase = 0;
                rcnt   = 0;
            end else if (rphase == 0) begin
                if (!mem_req_o) begin
                    rcnt = cfg_gd >= 0 ? cfg_gd : 32'($urandom_range(0, 2));
                end else if (rcnt > 0) begin
                    rcnt--;
                end else begin
                    accept(rsp);
                    mem_gnt_i = 1'b1;
                    rphase = cfg_drop ? 0 : 1;
                    rcnt = cfg_rd >= 1 ? cfg_rd : 32'($urandom_range(1, 3));
                    if (cfg_rvg) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = 32'hBAD0_BAD0;
                    end
                end
                if (cfg_noise && $urandom_range(0, 3) == 0) mem_rvalid_i = 1'b1;
            end else begin
                rcnt--;
                if (rcnt <= 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rsp;
                    rphase = 0;
                    rcnt = cfg_gd >= 0 ? cfg_gd : 32'($urandom_range(0, 2));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_valid_o) begin
                if (if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_unexpected: valid with nothing pending");
                end else begin
                    e = if_q.pop_front();
                    check("if_rdata", if_rdata_o, e.data);
                    check("if_err", 32'(if_err_o), 32'(e.err));
                end
            end else if (if_err_o) begin
                checks++; errors++;
                $display("FAIL if_err_alone: err without valid");
            end
            if (d_valid_o) begin
                if (d_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_unexpected: valid with nothing pending");
                end else begin
                    e = d_q.pop_front();
                    check("d_rdata", d_rdata_o, e.data);
                    check("d_err", 32'(d_err_o), 32'(e.err));
                end
            end else if (d_err_o) begin
                checks++; errors++;
                $display("FAIL d_err_alone: err without valid");
            end
        end
    end

    initial begin
        int n;
        bit early;
        if_req_i = 0; if_addr_i = '0;
        d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
        repeat (2) @(negedge clk);
        check("rst_if_valid", 32'(if_valid_o), 0);
        check("rst_if_err", 32'(if_err_o), 0);
        check("rst_if_rdata", if_rdata_o, 0);
        check("rst_d_valid", 32'(d_valid_o), 0);
        check("rst_d_err", 32'(d_err_o), 0);
        check("rst_d_rdata", d_rdata_o, 0);
        check("rst_mem_req", 32'(mem_req_o), 0);
        check("rst_mem_we", 32'(mem_we_o), 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        check("rst_mem_be", 32'(mem_be_o), 0);

        // fetch read right after reset release
        cfg_gd = 1; cfg_rd = 2; cfg_force = 1; cfg_data = 32'hDEAD_BEEF;
        rst = 1'b1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        if_q.push_back(mk(32'hDEAD_BEEF, 1'b0));
        @(negedge clk);
        check("first_req", 32'(mem_req_o), 1);
        check("f_addr", mem_addr_o, 32'h100);
        check("f_we", 32'(mem_we_o), 0);
        check("f_be", 32'(mem_be_o), 32'hF);
        wait_valid(1'b0, 20);
        if_req_i = 1'b0;
        @(negedge clk);
        check("f_pulse_once", 32'(if_valid_o), 0);
        cfg_force = 0; cfg_gd = -1; cfg_rd = -1;

        // tie after reset, then strict alternation
        do_reset();
        served_q.delete();
        run_ports(6, 1'b0);
        check("order_len", served_q.size(), 6);
        for (int i = 0; i < 6 && i < served_q.size(); i++)
            check("order", served_q[i], (i % 2 == 0) ? 1 : 0);

        // data write
        @(negedge clk);
        issue_d(1'b1, 32'h2000, 32'h1234_5678, 4'b0011);
        @(negedge clk);
        check("w_req", 32'(mem_req_o), 1);
        check("w_we", 32'(mem_we_o), 1);
        check("w_addr", mem_addr_o, 32'h2000);
        check("w_wdata", mem_wdata_o, 32'h1234_5678);
        check("w_be", 32'(mem_be_o), 32'h3);
        wait_valid(1'b1, 20);
        d_req_i = 1'b0;

        // timeout: no response ever comes
        cfg_drop = 1;
        @(negedge clk);
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2010; d_be_i = 4'hF;
        last_d = '0;
        d_q.push_back(mk(32'h0, 1'b1));
        @(negedge clk);
        check("tmo_req", 32'(mem_req_o), 1);
        early = 0;
        for (int k = 1; k < 15; k++) begin
            @(negedge clk);
            if (d_valid_o) early = 1;
        end
        check("tmo_early", 32'(early), 0);
        @(negedge clk);
        check("tmo_valid", 32'(d_valid_o), 1);
        check("tmo_err", 32'(d_err_o), 1);
        check("tmo_rdata", d_rdata_o, 0);
        d_req_i = 1'b0;
        cfg_drop = 0;
        @(negedge clk);
        check("tmo_idle", 32'(d_valid_o), 0);

        // grant and rvalid together count as grant only
        cfg_rvg = 1; cfg_gd = 1; cfg_rd = 2;
        issue_f(32'h1040);
        @(negedge clk);
        check("g_req", 32'(mem_req_o), 1);
        n = 0;
        while (mem_req_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("gnt_rv_no_done", 32'(if_valid_o), 0);
        cfg_rvg = 0;
        wait_valid(1'b0, 20);
        if_req_i = 1'b0;
        cfg_gd = -1; cfg_rd = -1;

        // reset while waiting for the response
        cfg_drop = 1;
        @(negedge clk);
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2020; d_be_i = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req_o && n < 10);
        do begin @(negedge clk); n++; end while (mem_req_o && n < 20);
        #2 rst = 1'b0;
        #1;
        check("ar_mem_req", 32'(mem_req_o), 0);
        check("ar_mem_addr", mem_addr_o, 0);
        check("ar_mem_be", 32'(mem_be_o), 0);
        check("ar_d_valid", 32'(d_valid_o), 0);
        check("ar_d_rdata", d_rdata_o, 0);
        check("ar_if_rdata", if_rdata_o, 0);
        if_req_i = 1'b0; d_req_i = 1'b0;
        if_q.delete(); d_q.delete();
        last_d = '0;
        cfg_drop = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        served_q.delete();
        run_ports(2, 1'b0);
        check("tie_after_rst", served_q.size() > 0 ? served_q[0] : 99, 1);

        // random traffic with stray rvalids
        cfg_noise = 1;
        run_ports(80, 1'b1);
        cfg_noise = 0;
        repeat (5) @(negedge clk);
        check("if_q_drained", if_q.size(), 0);
        check("d_q_drained", d_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
